// File: rtl/mc_muldiv_pkg.sv
// Shared definitions for the multicycle multiply/divide unit: operation
// encodings (also decoded by the CPU controller), FSM state codes and small
// op-decode helpers.
package mc_muldiv_pkg;

  typedef enum logic [1:0] {
    OpMult  = 2'b00,
    OpMultu = 2'b01,
    OpDiv   = 2'b10,
    OpDivu  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFin  = 2'b10
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/mc_muldiv_iter.sv
// One-step combinational kernel of the multiply/divide unit.
// Operates on a 2*WIDTH accumulator:
//   multiply: {partial product, remaining multiplier bits}, radix-2 shift-add
//   divide:   {partial remainder, dividend/quotient bits}, restoring shift-subtract
// Ports:
//   is_div   select divide step (1) or multiply step (0)
//   acc      current accumulator
//   m        multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_nxt  accumulator after one iteration
// Build option: MC_MULDIV_DIV_EN includes the divide step; without it only the
// multiply step exists.
module mc_muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     m,
  output logic [2*WIDTH-1:0]   acc_nxt
);

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_nxt;

  // Add multiplicand into the upper half when the current multiplier bit is
  // set, then shift the whole accumulator right (carry enters the top bit).
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) begin
      mul_sum = mul_sum + {1'b0, m};
    end
    mul_nxt = {mul_sum, acc[WIDTH-1:1]};
  end

`ifdef MC_MULDIV_DIV_EN
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   div_nxt;

  // Shift the next dividend bit into the remainder and try subtracting the
  // divisor; a borrow (top bit of diff) means restore and emit quotient 0.
  always_comb begin
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, m};
    if (diff[WIDTH]) begin
      div_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      div_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  assign acc_nxt = is_div ? div_nxt : mul_nxt;
`else
  // Divides never enter the iteration state in this build; hold the accumulator.
  assign acc_nxt = is_div ? acc : mul_nxt;
`endif

endmodule

// File: rtl/mc_muldiv.sv
// Multicycle multiply/divide unit with HI/LO registers for the multicycle CPU.
// MULT/MULTU/DIV/DIVU run one bit per cycle behind a start/busy/done handshake;
// HI/LO are also readable (MFHI/MFLO) and writable (MTHI/MTLO) while idle.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   start, op       launch op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU) when not busy
//   a, b            multiplicand/dividend, multiplier/divisor
//   wr_hi, wr_lo    MTHI/MTLO strobes with wdata, honoured only when not busy
//   busy            operation in progress
//   done            one-cycle pulse when hi/lo take the op result
//   div0            one-cycle pulse with done for divide by zero
//   hi, lo          HI (product high / remainder), LO (product low / quotient)
// Build option: MC_MULDIV_DIV_EN enables the divider. Without it DIV/DIVU
// finish after one cycle with done and div0 set and hi/lo left unchanged.
module mc_muldiv
  import mc_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e               state_q;
  logic                 is_div_q;
  logic                 neg_lo_q;   // negate product / quotient at fix-up
  logic                 zero_q;     // op finishes without iterating (div0 path)
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     m_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 div0_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
`ifdef MC_MULDIV_DIV_EN
  logic                 neg_hi_q;   // remainder follows the dividend's sign
`endif

  // Operand preparation for the start edge.
  logic                 start_sgn;
  logic                 start_div;
  logic                 start_zero;
  logic                 start_neg_lo;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [WIDTH-1:0]     start_low;
  logic [WIDTH-1:0]     start_m;

  always_comb begin
    start_sgn    = op_is_signed(op);
    start_div    = op_is_div(op);
    abs_a        = (start_sgn && a[WIDTH-1]) ? -a : a;
    abs_b        = (start_sgn && b[WIDTH-1]) ? -b : b;
    start_neg_lo = start_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MC_MULDIV_DIV_EN
    start_zero   = start_div && (b == '0);
`else
    start_zero   = start_div;
`endif
    // Divide-by-zero keeps the raw dividend in the low half so FIN can copy it to hi.
    start_low    = start_div ? (start_zero ? a : abs_a) : abs_b;
    start_m      = start_div ? abs_b : abs_a;
  end

  logic [2*WIDTH-1:0]   acc_nxt;

  mc_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .is_div  (is_div_q),
    .acc     (acc_q),
    .m       (m_q),
    .acc_nxt (acc_nxt)
  );

  // Sign fix-up of the finished magnitude result.
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     res_hi;
  logic [WIDTH-1:0]     res_lo;

  always_comb begin
    prod   = neg_lo_q ? -acc_q : acc_q;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef MC_MULDIV_DIV_EN
    if (is_div_q) begin
      res_lo = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      res_hi = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      zero_q   <= 1'b0;
      acc_q    <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MC_MULDIV_DIV_EN
      neg_hi_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      div0_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (wr_hi) begin
            hi_q <= wdata;
          end
          if (wr_lo) begin
            lo_q <= wdata;
          end
          if (start) begin
            is_div_q <= start_div;
            neg_lo_q <= start_neg_lo;
            zero_q   <= start_zero;
            acc_q    <= {{WIDTH{1'b0}}, start_low};
            m_q      <= start_m;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= start_zero ? StFin : StCalc;
`ifdef MC_MULDIV_DIV_EN
            neg_hi_q <= start_sgn && a[WIDTH-1];
`endif
          end
        end
        StCalc: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= StFin;
          end
        end
        StFin: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StIdle;
          if (zero_q) begin
            div0_q <= 1'b1;
`ifdef MC_MULDIV_DIV_EN
            hi_q   <= acc_q[WIDTH-1:0];
            lo_q   <= '1;
`endif
          end else begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
